hazard_controller: RTL and testbench

Pipeline control block for the 5-stage RV32 datapath: decides every cycle whether the Fetch stage holds its PC, whether it is redirected to a resolved branch target, and which pipeline registers are squashed. It detects load-use hazards, applies MEM-stage branch redirects, and runs a halt/drain handshake that quiesces the pipeline for debug. It also keeps saturating stall and flush counters. It sits beside the pipeline and drives Fetch's `stall`, `pc_src` and `branch_target` plus the per-register flush/hold controls.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 32 +++
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control logic: controller states,
// the canonical NOP encoding and default datapath widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_DRAIN_CYCLES   = 3;
  localparam int DEF_CNT_WIDTH      = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each edge where inc is high and
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/flow controller: load-use bubbles, MEM-stage branch
// redirects, a halt/drain handshake for debug, and stall/flush counters.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      mem_branch_taken,
  input  logic [ADDR_WIDTH-1:0]     mem_branch_target,
  input  logic                      halt_req,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      pc_src,
  output logic [ADDR_WIDTH-1:0]     branch_target,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      flush_mem,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_e    state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  logic lu;
  logic br;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  // A redirect must win over any hold because Fetch prioritises stall.
  assign br = mem_branch_taken && (state_q != HALTED);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_if    = 1'b0;
    pc_src      = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;

    if (br) begin
      pc_src    = 1'b1;
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (!br && (lu || halt_req)) begin
          stall_if = 1'b1;
          flush_ex = 1'b1;
        end
        if (!br && halt_req) begin
          state_d     = DRAIN;
          drain_cnt_d = DCW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (!br) begin
          stall_if = 1'b1;
          flush_ex = 1'b1;
        end
        // The drain runs to completion even if halt_req drops meanwhile.
        if (drain_cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      HALTED: begin
        stall_if = 1'b1;
        flush_ex = 1'b1;
        if (!halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign stall_id      = stall_if;
  assign branch_target = mem_branch_target;
  assign halted        = (state_q == HALTED);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_if),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, halt and
// reset sequences, counter saturation and randomized traffic vs. a model.
module tb_hazard_controller;

  localparam int AW = 12;
  localparam int RW = 5;
  localparam int DC = 3;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic          mem_branch_taken;
  logic [AW-1:0] mem_branch_target;
  logic          halt_req;
  logic          stall_if, stall_id, pc_src;
  logic [AW-1:0] branch_target;
  logic          flush_id, flush_ex, flush_mem, halted;
  logic [CW-1:0] stall_cycles, flush_events;

  hazard_controller #(
    .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_branch_taken(mem_branch_taken), .mem_branch_target(mem_branch_target),
    .halt_req(halt_req),
    .stall_if(stall_if), .stall_id(stall_id), .pc_src(pc_src),
    .branch_target(branch_target),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: edges since halt sequence began (-1 = running, DC or more = halted).
  int m_since_halt = -1;
  int m_stalls     = 0;
  int m_flushes    = 0;

  typedef struct packed {
    logic [RW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [RW-1:0] exrd;
    logic          mr, bt;
    logic [AW-1:0] tgt;
    logic          e_stall, e_pcsrc, e_fid, e_fex, e_fmem;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_lu();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit m_halted();
    return m_since_halt >= DC;
  endfunction

  function automatic bit m_br();
    return mem_branch_taken && !m_halted();
  endfunction

  function automatic bit m_stall();
    bit holding;
    holding = (m_since_halt >= 0) || halt_req || m_lu();
    return !m_br() && holding;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":stall_if"},  int'(stall_if),  int'(m_stall()));
    chk({tag, ":stall_id"},  int'(stall_id),  int'(m_stall()));
    chk({tag, ":pc_src"},    int'(pc_src),    int'(m_br()));
    chk({tag, ":flush_id"},  int'(flush_id),  int'(m_br()));
    chk({tag, ":flush_ex"},  int'(flush_ex),  int'(m_br() || m_stall()));
    chk({tag, ":flush_mem"}, int'(flush_mem), int'(m_br()));
    chk({tag, ":target"},    int'(branch_target), int'(mem_branch_target));
    chk({tag, ":halted"},    int'(halted),    int'(m_halted()));
    chk({tag, ":stall_cnt"}, int'(stall_cycles), m_stalls);
    chk({tag, ":flush_cnt"}, int'(flush_events), m_flushes);
  endtask

  // Advance one clock edge, updating the model from the inputs before it.
  task automatic model_edge();
    bit br, st, run_now;
    br = m_br();
    st = m_stall();
    run_now = (m_since_halt < 0);
    @(posedge clk);
    if (st && m_stalls < CNT_MAX) m_stalls++;
    if (br && m_flushes < CNT_MAX) m_flushes++;
    if (run_now) begin
      if (!br && halt_req) m_since_halt = 0;
    end else if (m_since_halt < DC) begin
      m_since_halt++;
    end else if (!halt_req) begin
      m_since_halt = -1;
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_edge();
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0; mem_branch_taken = 0;
    mem_branch_target = '0; halt_req = 0;
  endtask

  task automatic model_reset();
    m_since_halt = -1; m_stalls = 0; m_flushes = 0;
  endtask

  initial begin
    vecs[0] = '{rs1:0, rs2:0, u1:0, u2:0, exrd:0, mr:0, bt:0, tgt:12'h000, e_stall:0, e_pcsrc:0, e_fid:0, e_fex:0, e_fmem:0};
    vecs[1] = '{rs1:5, rs2:0, u1:1, u2:0, exrd:5, mr:1, bt:0, tgt:12'h000, e_stall:1, e_pcsrc:0, e_fid:0, e_fex:1, e_fmem:0};
    vecs[2] = '{rs1:0, rs2:0, u1:1, u2:0, exrd:0, mr:1, bt:0, tgt:12'h000, e_stall:0, e_pcsrc:0, e_fid:0, e_fex:0, e_fmem:0};
    vecs[3] = '{rs1:1, rs2:7, u1:1, u2:1, exrd:7, mr:1, bt:0, tgt:12'h000, e_stall:1, e_pcsrc:0, e_fid:0, e_fex:1, e_fmem:0};
    vecs[4] = '{rs1:9, rs2:0, u1:0, u2:0, exrd:9, mr:1, bt:0, tgt:12'h000, e_stall:0, e_pcsrc:0, e_fid:0, e_fex:0, e_fmem:0};
    vecs[5] = '{rs1:3, rs2:0, u1:1, u2:0, exrd:3, mr:0, bt:0, tgt:12'h000, e_stall:0, e_pcsrc:0, e_fid:0, e_fex:0, e_fmem:0};
    vecs[6] = '{rs1:0, rs2:0, u1:0, u2:0, exrd:0, mr:0, bt:1, tgt:12'h040, e_stall:0, e_pcsrc:1, e_fid:1, e_fex:1, e_fmem:1};
    vecs[7] = '{rs1:5, rs2:0, u1:1, u2:0, exrd:5, mr:1, bt:1, tgt:12'h7FC, e_stall:0, e_pcsrc:1, e_fid:1, e_fex:1, e_fmem:1};

    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    model_reset();
    #1 check_all("in_reset");
    reset = 0;

    // Directed vector table in RUN state.
    for (int i = 0; i < 8; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_rd = vecs[i].exrd; ex_mem_read = vecs[i].mr;
      mem_branch_taken = vecs[i].bt; mem_branch_target = vecs[i].tgt;
      #1;
      chk($sformatf("vec%0d:stall_if", i), int'(stall_if), int'(vecs[i].e_stall));
      chk($sformatf("vec%0d:stall_id", i), int'(stall_id), int'(vecs[i].e_stall));
      chk($sformatf("vec%0d:pc_src", i),   int'(pc_src),   int'(vecs[i].e_pcsrc));
      chk($sformatf("vec%0d:flush_id", i), int'(flush_id), int'(vecs[i].e_fid));
      chk($sformatf("vec%0d:flush_ex", i), int'(flush_ex), int'(vecs[i].e_fex));
      chk($sformatf("vec%0d:flush_mem", i), int'(flush_mem), int'(vecs[i].e_fmem));
      chk($sformatf("vec%0d:target", i),   int'(branch_target), int'(vecs[i].tgt));
      $display("[TB] vec%0d stall_if=%0d pc_src=%0d flush_ex=%0d", i, stall_if, pc_src, flush_ex);
      model_edge();
    end
    idle_inputs();
    #1;
    chk("table:stall_cnt", int'(stall_cycles), 2);
    chk("table:flush_cnt", int'(flush_events), 2);

    // Halt handshake: halted rises DC edges after the edge that leaves RUN.
    halt_req = 1;
    for (int i = 0; i <= DC; i++) begin
      step($sformatf("halt%0d", i));
      if (i == DC - 1) chk("halt:early", int'(halted), 0);
    end
    #1 chk("halt:sched", int'(halted), 1);
    step("halted_hold");
    halt_req = 0;
    step("resume");
    #1 chk("resume:halted", int'(halted), 0);
    chk("resume:stall_if", int'(stall_if), 0);

    // Branch during drain, with halt_req dropped mid-drain.
    halt_req = 1;
    step("bd_enter");
    mem_branch_taken = 1; mem_branch_target = 12'h0A4;
    step("bd_branch");
    mem_branch_taken = 0; halt_req = 0;
    for (int i = 0; i < 4; i++) step($sformatf("bd_tail%0d", i));
    $display("[TB] branch-in-drain sequence halted=%0d flushes=%0d", halted, flush_events);

    // Asynchronous reset in the middle of DRAIN.
    halt_req = 1;
    step("rd_enter");
    step("rd_drain");
    halt_req = 0;
    reset = 1;
    model_reset();
    #1 check_all("rd_reset");
    @(negedge clk);
    reset = 0;
    step("rd_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rd = RW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom);
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      mem_branch_target = AW'($urandom);
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      step("rand");
    end
    $display("[TB] random phase stall_cycles=%0d flush_events=%0d", stall_cycles, flush_events);

    // Hold halted long enough to saturate the stall counter.
    idle_inputs();
    halt_req = 1;
    for (int i = 0; i < CNT_MAX + 200; i++) step("sat");
    #1 chk("sat:stall_cnt", int'(stall_cycles), CNT_MAX);
    halt_req = 0;
    step("sat_exit");
    step("sat_run");
    $display("[TB] saturation stall_cycles=%0d", stall_cycles);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
